// File: rtl/cache_mem_arbiter.sv
// Single-port SDRAM arbiter shared by the I-cache fill path and D-cache fill/write-back path.
// One burst at a time; ties alternate based on the last granted requester.
module cache_mem_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              n_RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_wnext,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wnext,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    XFER,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              last_d;
  logic              last_d_n;
  logic              i_gnt_n;
  logic              d_gnt_n;
  logic              wren_n;
  logic [ADDR_W-1:0] addr_n;
  logic              xfer;
  logic              beat;
  logic              pick_d;

  assign xfer   = (state == XFER);
  // Only the beat kind matching the transaction direction advances the burst.
  assign beat   = mem_wren ? mem_wnext : mem_rvalid;
  assign pick_d = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk) begin
    if (!n_RST) begin
      state    <= IDLE;
      cnt      <= '0;
      last_d   <= 1'b0;
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      mem_wren <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last_d   <= last_d_n;
      i_gnt    <= i_gnt_n;
      d_gnt    <= d_gnt_n;
      mem_wren <= wren_n;
      mem_addr <= addr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_d_n = last_d;
    i_gnt_n  = i_gnt;
    d_gnt_n  = d_gnt;
    wren_n   = mem_wren;
    addr_n   = mem_addr;
    unique case (state)
      IDLE: begin
        if (i_req | d_req) begin
          state_n  = ISSUE;
          last_d_n = pick_d;
          i_gnt_n  = ~pick_d;
          d_gnt_n  = pick_d;
          wren_n   = pick_d & d_wren;
          addr_n   = pick_d ? d_addr : i_addr;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_n = XFER;
          cnt_n   = '0;
        end
      end
      XFER: begin
        if (beat) begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        i_gnt_n = 1'b0;
        d_gnt_n = 1'b0;
      end
    endcase
  end

  assign mem_req   = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign i_done    = (state == DONE) & i_gnt;
  assign d_done    = (state == DONE) & d_gnt;
  assign rdata     = mem_rdata;
  assign mem_wdata = d_wdata;
  assign i_rvalid  = mem_rvalid & i_gnt & xfer;
  assign d_rvalid  = mem_rvalid & d_gnt & ~mem_wren & xfer;
  assign d_wnext   = mem_wnext & d_gnt & mem_wren & xfer;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: the bench plays both caches and the
// SDRAM controller and predicts grants, beats and completions transaction by transaction.
module tb_cache_mem_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          n_RST = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid, i_done;
  logic          d_req = 1'b0;
  logic          d_wren = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid, d_wnext, d_done;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_wren;
  logic [AW-1:0] mem_addr;
  logic          mem_ready = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_wnext = 1'b0;
  logic [DW-1:0] mem_wdata;
  logic          busy;

  int vecs = 0;
  int errs = 0;
  bit last_d = 1'b0;
  bit i_pend = 1'b0;
  bit d_pend = 1'b0;
  bit wd;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .n_RST(n_RST),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_wnext(d_wnext), .d_done(d_done), .rdata(rdata),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_wnext(mem_wnext),
    .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic spurious();
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_wnext  = 1'($urandom_range(0, 1));
    mem_rdata  = DW'($urandom);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ignt"}, i_gnt, 0);
    chk({tag, "_dgnt"}, d_gnt, 0);
    chk({tag, "_mreq"}, mem_req, 0);
    chk({tag, "_idone"}, i_done, 0);
    chk({tag, "_ddone"}, d_done, 0);
    chk({tag, "_irv"}, i_rvalid, 0);
    chk({tag, "_drv"}, d_rvalid, 0);
    chk({tag, "_dwn"}, d_wnext, 0);
  endtask

  // Called in the arbitration cycle, after requests are driven.
  task automatic xfer(input bit w_d, input int abort);
    logic [AW-1:0] ea;
    bit ew;
    bit b;
    int w;
    int k;
    ea = w_d ? d_addr : i_addr;
    ew = w_d & d_wren;
    last_d = w_d;
    if (w_d) d_pend = 1'b0;
    else i_pend = 1'b0;
    w = $urandom_range(0, 3);
    for (int c = 0; c <= w; c++) begin
      @(negedge clk);
      spurious();
      mem_ready = (c == w);
      if (c == 0) begin
        if (w_d) d_addr = AW'($urandom);
        else i_addr = AW'($urandom);
      end
      #1;
      chk("iss_ignt", i_gnt, !w_d);
      chk("iss_dgnt", d_gnt, w_d);
      chk("iss_mreq", mem_req, 1);
      chk("iss_wren", mem_wren, ew);
      chk("iss_addr", mem_addr, ea);
      chk("iss_busy", busy, 1);
      chk("iss_irv", i_rvalid, 0);
      chk("iss_drv", d_rvalid, 0);
      chk("iss_dwn", d_wnext, 0);
      chk("iss_done", i_done | d_done, 0);
    end
    k = 0;
    while (k < BL) begin
      if (k == abort) return;
      @(negedge clk);
      mem_ready = 1'b0;
      spurious();
      b = 1'($urandom_range(0, 1));
      if (ew) mem_wnext = b;
      else mem_rvalid = b;
      d_wdata = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        if (w_d) d_req = 1'b0;
        else i_req = 1'b0;
      end
      #1;
      chk("x_mreq", mem_req, 0);
      chk("x_busy", busy, 1);
      chk("x_ignt", i_gnt, !w_d);
      chk("x_dgnt", d_gnt, w_d);
      chk("x_addr", mem_addr, ea);
      chk("x_irv", i_rvalid, !w_d && mem_rvalid);
      chk("x_drv", d_rvalid, w_d && !ew && mem_rvalid);
      chk("x_dwn", d_wnext, w_d && ew && mem_wnext);
      chk("x_rdata", rdata, mem_rdata);
      chk("x_wdata", mem_wdata, d_wdata);
      chk("x_done", i_done | d_done, 0);
      if (b) k++;
    end
    @(negedge clk);
    spurious();
    if (w_d) d_req = 1'b0;
    else i_req = 1'b0;
    #1;
    chk("dn_idone", i_done, !w_d);
    chk("dn_ddone", d_done, w_d);
    chk("dn_ignt", i_gnt, !w_d);
    chk("dn_dgnt", d_gnt, w_d);
    chk("dn_busy", busy, 1);
    chk("dn_mreq", mem_req, 0);
    chk("dn_irv", i_rvalid, 0);
    chk("dn_drv", d_rvalid, 0);
    chk("dn_dwn", d_wnext, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_idle("rst0");
    chk("rst0_addr", mem_addr, 0);
    chk("rst0_wren", mem_wren, 0);
    @(negedge clk);
    n_RST  = 1'b1;
    i_req  = 1'b1;
    i_addr = 24'h000100;
    #1;
    chk_idle("pre");
    xfer(1'b0, 2);
    @(negedge clk);
    n_RST = 1'b0;
    i_req = 1'b0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_wnext = 1'b0;
    @(negedge clk);
    #1;
    chk_idle("rst1");
    chk("rst1_addr", mem_addr, 0);
    chk("rst1_wren", mem_wren, 0);
    last_d = 1'b0;
    i_pend = 1'b0;
    d_pend = 1'b0;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      n_RST = 1'b1;
      mem_ready = 1'b0;
      spurious();
      if (!i_pend && (it < 3 || $urandom_range(0, 2) == 0)) begin
        i_pend = 1'b1;
        i_addr = AW'($urandom);
      end
      if (!d_pend && (it < 3 || $urandom_range(0, 1) == 0)) begin
        d_pend = 1'b1;
        d_addr = AW'($urandom);
        d_wren = 1'($urandom_range(0, 1));
      end
      i_req = i_pend;
      d_req = d_pend;
      #1;
      chk_idle("idle");
      if (i_pend || d_pend) begin
        wd = (i_pend && d_pend) ? !last_d : d_pend;
        xfer(wd, -1);
      end
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    #1;
    chk_idle("end");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single SDRAM controller port between the I-cache line-fill path and the D-cache line-fill/write-back path.
- Sequences one burst transaction at a time: grant, issue, beat counting, completion.
- Routes read data to the granted cache and write data from it.
- The D-cache stall seen by the hazard logic (d_cache_miss) is held until this block pulses d_done.

Parameters:
- ADDR_W, 24, word address width of cache and SDRAM ports.
- DATA_W, 16, data word width.
- BURST_LEN, 4, words per cache line (power of two, 2..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_RST  in  1  synchronous active-low reset.
- i_req  in  1  I-cache line-fill request (level, held until i_done).
- i_addr  in  ADDR_W  I-cache line base address.
- i_gnt  out  1  I-cache owns the port.
- i_rvalid  out  1  read beat valid for I-cache.
- i_done  out  1  one-cycle I transaction completion.
- d_req  in  1  D-cache request (level, held until d_done).
- d_wren  in  1  1 = write-back, 0 = line fill.
- d_addr  in  ADDR_W  D-cache line base address.
- d_wdata  in  DATA_W  current write-back word.
- d_gnt  out  1  D-cache owns the port.
- d_rvalid  out  1  read beat valid for D-cache.
- d_wnext  out  1  advance D write-back word pointer.
- d_done  out  1  one-cycle D transaction completion.
- rdata  out  DATA_W  mem_rdata passthrough, shared by both caches.
- mem_req  out  1  transaction request to SDRAM controller.
- mem_wren  out  1  transaction is a write.
- mem_addr  out  ADDR_W  latched line base address.
- mem_ready  in  1  controller accepted mem_req this cycle.
- mem_rvalid  in  1  read beat present on mem_rdata.
- mem_rdata  in  DATA_W  read data.
- mem_wnext  in  1  controller consumed mem_wdata this cycle.
- mem_wdata  out  DATA_W  d_wdata passthrough.
- busy  out  1  state != IDLE.

Behaviour:
- **States:** IDLE, ISSUE, XFER, DONE.
- **IDLE:** sample requests.
  - Only one requesting: grant it.
  - Both requesting: grant the one not granted last (last_grant register).
  - On grant: latch addr and wren into mem_addr/mem_wren (I forces wren=0), set last_grant, assert x_gnt, go to ISSUE.
  - No request: stay in IDLE.
- **ISSUE:** mem_req=1 until mem_ready=1 is sampled. On that cycle go to XFER, beat counter = 0, mem_req drops the next cycle.
- **XFER:** counter increments on mem_rvalid (read) or mem_wnext (write). On the edge where counter == BURST_LEN-1 and a beat occurs, go to DONE.
- **DONE:** x_done=1 for exactly one cycle, x_gnt still 1, then IDLE with gnt cleared.
  - Requester must drop req on the edge ending DONE.
  - The next arbitration happens in the IDLE cycle after DONE, so at least 1 idle cycle separates transactions.
- **Data routing (combinational):**
  - rdata = mem_rdata.
  - i_rvalid = mem_rvalid & i_gnt & XFER.
  - d_rvalid = mem_rvalid & d_gnt & ~mem_wren & XFER.
  - d_wnext = mem_wnext & d_gnt & mem_wren & XFER.
  - mem_wdata = d_wdata.
- **Ignored inputs:**
  - mem_rvalid/mem_wnext outside XFER, and the wrong kind for the current direction.
  - Request deassertion during ISSUE/XFER: the transaction completes anyway.
  - Address changes after grant.
- **Latency:** req high in IDLE at cycle t → gnt and mem_req at t+1. Minimum transaction length BURST_LEN+3 cycles.
- **Reset (n_RST=0 at a clock edge):** state=IDLE, counter=0, last_grant=I (first tie goes to D). All outputs 0: mem_req, mem_wren, mem_addr, gnt, done, busy, rvalid/wnext gating. Reset mid-transaction aborts it; the SDRAM controller is reset by the same n_RST.

Test Plan:
- **Reset:** n_RST=0 for 2 cycles mid-XFER → next cycle busy=0, mem_req=0, i_gnt=d_gnt=0, mem_addr=0.
- **I fill:** i_req=1, i_addr=24'h000100; mem_ready after 3 cycles; 4 mem_rvalid beats 0xA0..0xA3 → mem_req high exactly 4 cycles (t+1..t+4), i_rvalid×4 with rdata A0..A3, i_done 1 cycle after beat 4, d_rvalid never 1.
- **D write-back:** d_req=1, d_wren=1, d_addr=24'h00ABC0; mem_wnext on 4 non-consecutive cycles → mem_wren=1, d_wnext pulses ×4 aligned with mem_wnext, d_done once; spurious mem_rvalid during XFER → no d_rvalid, counter unchanged.
- **Simultaneous requests after reset:** d wins; after d_done with both still pending, I is granted; a third tie goes to D again (alternation D, I, D).
- **Robustness:** mem_rvalid pulses in IDLE/ISSUE are ignored; i_req dropped during XFER still yields 4 beats and i_done; a 5th beat after DONE is ignored (no rvalid, no state change).
- **Back-to-back D requests:** d_req re-asserted 1 cycle after d_done → gnt reasserts 1 cycle later; busy low for exactly 1 cycle between transactions.
